// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges stall requests into a per-stage stall vector, turns exceptions into
// multi-cycle flushes deferred by freeze requests, and tracks stall watchdog/perf counters.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ = 4,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] REQ_MASK = {6'h3f, 6'h3f, 6'h07, 6'h3f},
  parameter logic [NUM_REQ-1:0] FREEZE_MASK = 4'b1001,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_TMO = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    stall_req,
  input  logic                  except_en,
  output logic                  flush,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush_pending,
  output logic                  stall_timeout,
  output logic [31:0]           stall_cycles
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(STALL_TMO + 1);
  logic [NUM_STAGES-1:0] fmask, amask;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic pend_flush_q, pend_flush_d, timeout_q, timeout_d;
  logic frz, fl_busy, stalled;
  // Request masks are listed request 0 first, so slice i sits at the high end of REQ_MASK.
  always_comb begin
    fmask = '0;
    amask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      amask = amask | (stall_req[i] ? REQ_MASK[(NUM_REQ-1-i)*NUM_STAGES +: NUM_STAGES] : '0);
      fmask = fmask | ((stall_req[i] & FREEZE_MASK[i]) ? REQ_MASK[(NUM_REQ-1-i)*NUM_STAGES +: NUM_STAGES] : '0);
    end
  end
  assign frz = |(stall_req & FREEZE_MASK);
  assign fl_busy = (flush_cnt_q != '0) | pend_flush_q;
  assign flush = resetn & ~frz & (fl_busy | except_en);
  assign stall = !resetn ? '0 : frz ? fmask : (fl_busy | except_en) ? '0 : amask;
  assign stalled = |stall;
  always_comb begin
    pend_flush_d = pend_flush_q;
    flush_cnt_d = flush_cnt_q;
    if (except_en && frz) begin
      pend_flush_d = 1'b1;
    end else if (except_en || (pend_flush_q && !frz)) begin
      flush_cnt_d = CW'(FLUSH_CYCLES - 1);
      pend_flush_d = 1'b0;
    end else if (flush_cnt_q != '0 && !frz) begin
      flush_cnt_d = flush_cnt_q - 1'b1;
    end
  end
  assign tmo_cnt_d = !stalled ? '0 : (tmo_cnt_q == TW'(STALL_TMO)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  assign timeout_d = timeout_q | (stalled & (tmo_cnt_q >= TW'(STALL_TMO - 1)));
  assign stall_cycles_d = stall_cycles_q + {31'd0, stalled};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_flush_q <= 1'b0;
      flush_cnt_q <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pend_flush_q <= pend_flush_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign flush_pending = pend_flush_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with hand-computed expectations for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic resetn;
  logic [3:0] stall_req;
  logic except_en;
  logic flush, flush_pending, stall_timeout;
  logic [5:0] stall;
  logic [31:0] stall_cycles;
  int errors = 0;
  int checks = 0;
  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .STALL_TMO(8)) dut (
    .clk(clk), .resetn(resetn), .stall_req(stall_req), .except_en(except_en),
    .flush(flush), .stall(stall), .flush_pending(flush_pending),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    resetn = 1'b0;
    stall_req = 4'b0100;
    except_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_pend", 32'(flush_pending), 32'h0);
    chk("rst_tmo", 32'(stall_timeout), 32'h0);
    chk("rst_cyc", stall_cycles, 32'h0);
    tick();
    resetn = 1'b1;
    except_en = 1'b0;
    stall_req = 4'b0000;
    @(negedge clk);
    chk("rst_no_flush", 32'(flush), 32'h0);
    chk("rst_no_pend", 32'(flush_pending), 32'h0);
    // masks
    tick();
    stall_req = 4'b0100;
    @(negedge clk);
    chk("mask_0100", 32'(stall), 32'h07);
    chk("mask_0100_fl", 32'(flush), 32'h0);
    tick();
    stall_req = 4'b0110;
    @(negedge clk);
    chk("mask_0110", 32'(stall), 32'h3f);
    tick();
    stall_req = 4'b0000;
    @(negedge clk);
    chk("mask_idle", 32'(stall), 32'h0);
    chk("cyc_2", stall_cycles, 32'd2);
    // flush window of 3 cycles
    tick();
    except_en = 1'b1;
    @(negedge clk);
    chk("fl_c1", 32'(flush), 32'h1);
    chk("fl_c1_st", 32'(stall), 32'h0);
    tick();
    except_en = 1'b0;
    stall_req = 4'b0100;
    @(negedge clk);
    chk("fl_c2", 32'(flush), 32'h1);
    chk("fl_c2_st", 32'(stall), 32'h0);
    tick();
    @(negedge clk);
    chk("fl_c3", 32'(flush), 32'h1);
    chk("fl_c3_st", 32'(stall), 32'h0);
    tick();
    @(negedge clk);
    chk("fl_c4", 32'(flush), 32'h0);
    chk("fl_c4_st", 32'(stall), 32'h07);
    tick();
    stall_req = 4'b0000;
    @(negedge clk);
    chk("cyc_3", stall_cycles, 32'd3);
    // deferred flush
    tick();
    stall_req = 4'b0001;
    except_en = 1'b1;
    @(negedge clk);
    chk("df_c1_st", 32'(stall), 32'h3f);
    chk("df_c1_fl", 32'(flush), 32'h0);
    chk("df_c1_pd", 32'(flush_pending), 32'h0);
    tick();
    except_en = 1'b0;
    @(negedge clk);
    chk("df_c2_pd", 32'(flush_pending), 32'h1);
    chk("df_c2_fl", 32'(flush), 32'h0);
    chk("df_c2_st", 32'(stall), 32'h3f);
    tick();
    tick();
    @(negedge clk);
    chk("df_c4_pd", 32'(flush_pending), 32'h1);
    chk("df_c4_fl", 32'(flush), 32'h0);
    tick();
    stall_req = 4'b0000;
    @(negedge clk);
    chk("df_c5_fl", 32'(flush), 32'h1);
    chk("df_c5_st", 32'(stall), 32'h0);
    tick();
    @(negedge clk);
    chk("df_c6_pd", 32'(flush_pending), 32'h0);
    chk("df_c6_fl", 32'(flush), 32'h1);
    tick();
    tick();
    @(negedge clk);
    chk("df_c8_fl", 32'(flush), 32'h0);
    chk("cyc_7", stall_cycles, 32'd7);
    // freeze pauses a running flush
    tick();
    except_en = 1'b1;
    @(negedge clk);
    chk("fz_c1", 32'(flush), 32'h1);
    tick();
    except_en = 1'b0;
    stall_req = 4'b1000;
    @(negedge clk);
    chk("fz_c2_fl", 32'(flush), 32'h0);
    chk("fz_c2_st", 32'(stall), 32'h3f);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("fz_c5_fl", 32'(flush), 32'h0);
    tick();
    stall_req = 4'b0000;
    @(negedge clk);
    chk("fz_c6_fl", 32'(flush), 32'h1);
    tick();
    @(negedge clk);
    chk("fz_c7_fl", 32'(flush), 32'h1);
    tick();
    @(negedge clk);
    chk("fz_c8_fl", 32'(flush), 32'h0);
    chk("cyc_11", stall_cycles, 32'd11);
    // watchdog
    stall_req = 4'b0100;
    repeat (7) tick();
    @(negedge clk);
    chk("wd_7", 32'(stall_timeout), 32'h0);
    stall_req = 4'b0000;
    tick();
    stall_req = 4'b0100;
    repeat (7) tick();
    @(negedge clk);
    chk("wd_7b", 32'(stall_timeout), 32'h0);
    tick();
    @(negedge clk);
    chk("wd_8", 32'(stall_timeout), 32'h1);
    stall_req = 4'b0000;
    tick();
    @(negedge clk);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);
    chk("cyc_26", stall_cycles, 32'd26);
    // perf counter wrap
    force dut.stall_cycles_q = 32'hfffffffe;
    #1;
    release dut.stall_cycles_q;
    tick();
    stall_req = 4'b0100;
    repeat (3) tick();
    stall_req = 4'b0000;
    @(negedge clk);
    chk("cyc_wrap", stall_cycles, 32'h1);
    // reset mid-flush
    tick();
    except_en = 1'b1;
    tick();
    except_en = 1'b0;
    @(negedge clk);
    chk("rm_fl", 32'(flush), 32'h1);
    resetn = 1'b0;
    #1;
    chk("rm_gated", 32'(flush), 32'h0);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    chk("rm_flush", 32'(flush), 32'h0);
    chk("rm_stall", 32'(stall), 32'h0);
    chk("rm_pend", 32'(flush_pending), 32'h0);
    chk("rm_tmo", 32'(stall_timeout), 32'h0);
    chk("rm_cyc", stall_cycles, 32'h0);
    tick();
    @(negedge clk);
    chk("rm_no_resid", 32'(flush), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
